// File: rtl/tcp_tx_segment_framer_if.sv
// Stream bundle for the TCP TX segment framer: result data, session IDs, TX metadata/data, status.
// The slave modport is the framer's view; master is the surrounding environment's view.
interface tcp_tx_segment_framer_if #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned SESS_WIDTH = 16,
  parameter int unsigned LEN_WIDTH  = 16
) ();
  logic                            s_axis_data_TVALID;
  logic                            s_axis_data_TREADY;
  logic [DATA_WIDTH-1:0]           s_axis_data_TDATA;
  logic [DATA_WIDTH/8-1:0]         s_axis_data_TKEEP;
  logic                            s_axis_data_TLAST;
  logic                            s_axis_session_TVALID;
  logic                            s_axis_session_TREADY;
  logic [SESS_WIDTH-1:0]           s_axis_session_TDATA;
  logic                            m_axis_tx_metadata_TVALID;
  logic                            m_axis_tx_metadata_TREADY;
  logic [LEN_WIDTH+SESS_WIDTH-1:0] m_axis_tx_metadata_TDATA;
  logic                            m_axis_tx_data_TVALID;
  logic                            m_axis_tx_data_TREADY;
  logic [DATA_WIDTH-1:0]           m_axis_tx_data_TDATA;
  logic [DATA_WIDTH/8-1:0]         m_axis_tx_data_TKEEP;
  logic                            m_axis_tx_data_TLAST;
  logic                            s_axis_tx_status_TVALID;
  logic                            s_axis_tx_status_TREADY;
  logic [63:0]                     s_axis_tx_status_TDATA;

  modport slave (
    input  s_axis_data_TVALID, s_axis_data_TDATA, s_axis_data_TKEEP, s_axis_data_TLAST,
    output s_axis_data_TREADY,
    input  s_axis_session_TVALID, s_axis_session_TDATA,
    output s_axis_session_TREADY,
    output m_axis_tx_metadata_TVALID, m_axis_tx_metadata_TDATA,
    input  m_axis_tx_metadata_TREADY,
    output m_axis_tx_data_TVALID, m_axis_tx_data_TDATA, m_axis_tx_data_TKEEP, m_axis_tx_data_TLAST,
    input  m_axis_tx_data_TREADY,
    input  s_axis_tx_status_TVALID, s_axis_tx_status_TDATA,
    output s_axis_tx_status_TREADY
  );

  modport master (
    output s_axis_data_TVALID, s_axis_data_TDATA, s_axis_data_TKEEP, s_axis_data_TLAST,
    input  s_axis_data_TREADY,
    output s_axis_session_TVALID, s_axis_session_TDATA,
    input  s_axis_session_TREADY,
    input  m_axis_tx_metadata_TVALID, m_axis_tx_metadata_TDATA,
    output m_axis_tx_metadata_TREADY,
    input  m_axis_tx_data_TVALID, m_axis_tx_data_TDATA, m_axis_tx_data_TKEEP, m_axis_tx_data_TLAST,
    output m_axis_tx_data_TREADY,
    output s_axis_tx_status_TVALID, s_axis_tx_status_TDATA,
    input  s_axis_tx_status_TREADY
  );
endinterface

// File: rtl/tcp_tx_segment_framer.sv
// Store-and-forward TX framer: cuts messages into segments of at most MAX_BEATS beats and
// emits {length, session} metadata ahead of each segment. Optional macro: TX_STATUS_CHECK_EN.
module tcp_tx_segment_framer #(
  parameter int unsigned DATA_WIDTH     = 512,
  parameter int unsigned SESS_WIDTH     = 16,
  parameter int unsigned LEN_WIDTH      = 16,
  parameter int unsigned MAX_BEATS      = 22,
  parameter int unsigned SESS_FIFO_BITS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  tcp_tx_segment_framer_if.slave        bus,
  output logic [15:0]                   err_count,
  output logic                          err_sticky
);
  localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned BEAT_W     = $clog2(MAX_BEATS + 1);
  localparam int unsigned IDX_W      = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam int unsigned CNT_W      = LEN_WIDTH + 1;
  localparam int unsigned SP_W       = SESS_FIFO_BITS + 1;
  localparam int unsigned SESS_DEPTH = 1 << SESS_FIFO_BITS;
  localparam logic [LEN_WIDTH-1:0] LEN_MAX = '1;

  if (64'(MAX_BEATS) * 64'(KEEP_WIDTH) > (64'd1 << LEN_WIDTH) - 64'd1) begin : g_len_check
    $error("MAX_BEATS * DATA_WIDTH/8 does not fit in LEN_WIDTH");
  end

  typedef enum logic [1:0] {StIdle, StFill, StMeta, StDrain} state_e;

  state_e                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   byte_cnt_q, byte_cnt_d;
  logic [BEAT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic [BEAT_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic                   more_q, more_d;
  logic [SESS_WIDTH-1:0]  sess_q, sess_d;
  logic [SP_W-1:0]        sf_wr_q, sf_rd_q;
  logic [SESS_WIDTH-1:0]  sess_mem [SESS_DEPTH];
  logic [DATA_WIDTH-1:0]  buf_data [MAX_BEATS];
  logic [KEEP_WIDTH-1:0]  buf_keep [MAX_BEATS];

  logic sf_empty, sf_full, sf_push, sf_pop;
  logic data_ready, meta_valid, tx_valid, tx_last, buf_wr;
  logic [CNT_W-1:0]      byte_sum;
  logic [SESS_WIDTH-1:0] sf_head;

  function automatic logic [CNT_W-1:0] popcount(input logic [KEEP_WIDTH-1:0] keep);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < KEEP_WIDTH; i++) cnt = cnt + CNT_W'(keep[i]);
    return cnt;
  endfunction

  // Session queue: pointers carry an extra wrap bit to tell full from empty.
  assign sf_empty = (sf_wr_q == sf_rd_q);
  assign sf_full  = (sf_wr_q[SP_W-1] != sf_rd_q[SP_W-1]) &&
                    (sf_wr_q[SP_W-2:0] == sf_rd_q[SP_W-2:0]);
  assign sf_push  = bus.s_axis_session_TVALID && !sf_full;
  assign sf_head  = sess_mem[sf_rd_q[SP_W-2:0]];
  assign byte_sum = {1'b0, byte_cnt_q} + popcount(bus.s_axis_data_TKEEP);

  always_ff @(posedge clk) begin
    if (sf_push) sess_mem[sf_wr_q[SP_W-2:0]] <= bus.s_axis_session_TDATA;
    if (buf_wr) begin
      buf_data[beat_cnt_q[IDX_W-1:0]] <= bus.s_axis_data_TDATA;
      buf_keep[beat_cnt_q[IDX_W-1:0]] <= bus.s_axis_data_TKEEP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      byte_cnt_q <= '0;
      beat_cnt_q <= '0;
      rd_ptr_q   <= '0;
      more_q     <= 1'b0;
      sess_q     <= '0;
      sf_wr_q    <= '0;
      sf_rd_q    <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      more_q     <= more_d;
      sess_q     <= sess_d;
      if (sf_push) sf_wr_q <= sf_wr_q + SP_W'(1);
      if (sf_pop)  sf_rd_q <= sf_rd_q + SP_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    beat_cnt_d = beat_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    more_d     = more_q;
    sess_d     = sess_q;
    data_ready = 1'b0;
    meta_valid = 1'b0;
    tx_valid   = 1'b0;
    tx_last    = 1'b0;
    buf_wr     = 1'b0;
    sf_pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!sf_empty) begin
          sess_d  = sf_head;
          state_d = StFill;
        end
      end
      StFill: begin
        data_ready = 1'b1;
        if (bus.s_axis_data_TVALID) begin
          buf_wr     = 1'b1;
          byte_cnt_d = byte_sum[LEN_WIDTH] ? LEN_MAX : byte_sum[LEN_WIDTH-1:0];
          beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          if (bus.s_axis_data_TLAST) begin
            sf_pop  = 1'b1;
            more_d  = 1'b0;
            state_d = StMeta;
          end else if (beat_cnt_q == BEAT_W'(MAX_BEATS - 1)) begin
            // Cut without TLAST: session stays at the queue head for the next segment.
            more_d  = 1'b1;
            state_d = StMeta;
          end
        end
      end
      StMeta: begin
        meta_valid = 1'b1;
        if (bus.m_axis_tx_metadata_TREADY) state_d = StDrain;
      end
      StDrain: begin
        tx_valid = (rd_ptr_q != beat_cnt_q);
        tx_last  = (rd_ptr_q == beat_cnt_q - BEAT_W'(1));
        if (tx_valid && bus.m_axis_tx_data_TREADY) begin
          rd_ptr_d = rd_ptr_q + BEAT_W'(1);
          if (tx_last) begin
            rd_ptr_d   = '0;
            beat_cnt_d = '0;
            byte_cnt_d = '0;
            state_d    = more_q ? StFill : StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.s_axis_data_TREADY        = data_ready;
  assign bus.s_axis_session_TREADY     = !sf_full;
  assign bus.m_axis_tx_metadata_TVALID = meta_valid;
  assign bus.m_axis_tx_metadata_TDATA  = {byte_cnt_q, sess_q};
  assign bus.m_axis_tx_data_TVALID     = tx_valid;
  assign bus.m_axis_tx_data_TDATA      = buf_data[rd_ptr_q[IDX_W-1:0]];
  assign bus.m_axis_tx_data_TKEEP      = buf_keep[rd_ptr_q[IDX_W-1:0]];
  assign bus.m_axis_tx_data_TLAST      = tx_last;
  assign bus.s_axis_tx_status_TREADY   = 1'b1;

`ifdef TX_STATUS_CHECK_EN
  logic [15:0] err_count_q;
  logic        err_sticky_q;
  logic        status_err;
  logic        unused_status;

  assign status_err    = bus.s_axis_tx_status_TVALID && (bus.s_axis_tx_status_TDATA[63:62] != 2'b00);
  assign unused_status = ^bus.s_axis_tx_status_TDATA[61:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count_q  <= '0;
      err_sticky_q <= 1'b0;
    end else if (status_err) begin
      if (err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
      err_sticky_q <= 1'b1;
    end
  end

  assign err_count  = err_count_q;
  assign err_sticky = err_sticky_q;
`else
  logic unused_status;
  assign unused_status = ^{bus.s_axis_tx_status_TVALID, bus.s_axis_tx_status_TDATA};
  assign err_count     = '0;
  assign err_sticky    = 1'b0;
`endif

endmodule

// File: tb/tb_tcp_tx_segment_framer.sv
// Randomized self-checking bench for tcp_tx_segment_framer: a message-level model predicts the
// metadata and segmented beat stream; monitors on the falling edge score every handshake.
module tb_tcp_tx_segment_framer;
  localparam int DW  = 512;
  localparam int KW  = DW / 8;
  localparam int SW  = 16;
  localparam int LW  = 16;
  localparam int MB  = 22;
  localparam int TMO = 3000;
`ifdef TX_STATUS_CHECK_EN
  localparam bit StatusEn = 1'b1;
`else
  localparam bit StatusEn = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] err_count;
  logic        err_sticky;

  always #5 clk = ~clk;

  tcp_tx_segment_framer_if #(.DATA_WIDTH(DW), .SESS_WIDTH(SW), .LEN_WIDTH(LW)) bus ();

  tcp_tx_segment_framer #(
    .DATA_WIDTH(DW), .SESS_WIDTH(SW), .LEN_WIDTH(LW), .MAX_BEATS(MB), .SESS_FIFO_BITS(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .err_count (err_count),
    .err_sticky(err_sticky)
  );

  int total = 0;
  int bad   = 0;

  logic [SW-1:0]    sess_send[$];
  beat_t            beat_send[$];
  logic [LW+SW-1:0] exp_meta[$];
  beat_t            exp_beat[$];

  bit mon_en     = 1'b0;
  bit meta_hold  = 1'b0;
  bit rand_ready = 1'b0;
  int tx_mode    = 0;    // 0: always ready, 1: random, 2: follow tx_force
  bit tx_force   = 1'b0;
  int gap_max    = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [KW-1:0] keep_n(input int n);
    logic [KW-1:0] m;
    m = '0;
    for (int i = 0; i < n; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Model: a message is cut every MB beats; each cut carries TLAST and its own byte total.
  task automatic add_msg(input logic [SW-1:0] sess, input int nbeats, input int last_bytes,
                         input bit rand_keep);
    int    seg_bytes;
    int    seg_beats;
    beat_t b;
    beat_t e;
    seg_bytes = 0;
    seg_beats = 0;
    sess_send.push_back(sess);
    for (int i = 0; i < nbeats; i++) begin
      b.d = rand_data();
      if (i == nbeats - 1) b.k = keep_n(last_bytes);
      else if (rand_keep) begin
        case ($urandom_range(0, 3))
          0:       b.k = '0;
          1:       b.k = keep_n($urandom_range(1, KW));
          default: b.k = '1;
        endcase
      end else b.k = '1;
      b.l = (i == nbeats - 1);
      beat_send.push_back(b);
      seg_bytes += $countones(b.k);
      seg_beats++;
      e   = b;
      e.l = b.l || (seg_beats == MB);
      exp_beat.push_back(e);
      if (e.l) begin
        exp_meta.push_back({(seg_bytes > 65535) ? 16'hFFFF : 16'(seg_bytes), sess});
        seg_bytes = 0;
        seg_beats = 0;
      end
    end
  endtask

  task automatic gap();
    repeat ($urandom_range(0, gap_max)) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Entered and left at posedge+1.
  task automatic send_session(input logic [SW-1:0] s);
    int n;
    n = 0;
    bus.s_axis_session_TVALID = 1'b1;
    bus.s_axis_session_TDATA  = s;
    @(negedge clk);
    while (!bus.s_axis_session_TREADY && n < TMO) begin
      @(negedge clk);
      n++;
    end
    check("session_accept_in_time", 32'(n < TMO), 1);
    @(posedge clk);
    #1;
    bus.s_axis_session_TVALID = 1'b0;
  endtask

  task automatic send_beat(input beat_t b);
    int n;
    n = 0;
    bus.s_axis_data_TVALID = 1'b1;
    bus.s_axis_data_TDATA  = b.d;
    bus.s_axis_data_TKEEP  = b.k;
    bus.s_axis_data_TLAST  = b.l;
    @(negedge clk);
    while (!bus.s_axis_data_TREADY && n < TMO) begin
      @(negedge clk);
      n++;
    end
    check("data_accept_in_time", 32'(n < TMO), 1);
    @(posedge clk);
    #1;
    bus.s_axis_data_TVALID = 1'b0;
  endtask

  task automatic send_all();
    logic [SW-1:0] s;
    beat_t         b;
    fork
      while (sess_send.size() > 0) begin
        s = sess_send.pop_front();
        gap();
        send_session(s);
      end
      while (beat_send.size() > 0) begin
        b = beat_send.pop_front();
        gap();
        send_beat(b);
      end
    join
  endtask

  task automatic run_traffic();
    int n;
    n = 0;
    @(posedge clk);
    #1;
    send_all();
    while ((exp_meta.size() != 0 || exp_beat.size() != 0) && n < TMO) begin
      @(posedge clk);
      n++;
    end
    check("drain_in_time", 32'(n < TMO), 1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("idle_no_accept", 32'(bus.s_axis_data_TREADY), 0);
  endtask

  task automatic send_status(input logic [1:0] err);
    @(posedge clk);
    #1;
    bus.s_axis_tx_status_TVALID = 1'b1;
    bus.s_axis_tx_status_TDATA  = {err, 30'($urandom), 16'd64, 16'($urandom)};
    @(negedge clk);
    check("status_ready", 32'(bus.s_axis_tx_status_TREADY), 1);
    @(posedge clk);
    #1;
    bus.s_axis_tx_status_TVALID = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    bus.m_axis_tx_metadata_TREADY = meta_hold ? 1'b0 :
                                    (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
    bus.m_axis_tx_data_TREADY = (tx_mode == 2) ? tx_force :
                                (tx_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  bit    open_seg = 1'b0;
  int    cyc      = 0;
  int    meta_cyc = 0;
  beat_t mon_e;

  always @(negedge clk) begin
    if (!rst && mon_en) begin
      cyc++;
      if (bus.m_axis_tx_metadata_TVALID && bus.m_axis_tx_metadata_TREADY) begin
        if (exp_meta.size() == 0) check("meta_extra", 32'(bus.m_axis_tx_metadata_TVALID), 0);
        else check("meta", DW'(bus.m_axis_tx_metadata_TDATA), DW'(exp_meta.pop_front()));
        check("meta_while_segment_open", 32'(open_seg), 0);
        open_seg = 1'b1;
        meta_cyc = cyc;
      end
      if (bus.m_axis_tx_data_TVALID && bus.m_axis_tx_data_TREADY) begin
        check("data_after_meta", 32'(open_seg && cyc > meta_cyc), 1);
        if (exp_beat.size() == 0) check("data_extra", 32'(bus.m_axis_tx_data_TVALID), 0);
        else begin
          mon_e = exp_beat.pop_front();
          check("tx_data", bus.m_axis_tx_data_TDATA, mon_e.d);
          check("tx_keep", DW'(bus.m_axis_tx_data_TKEEP), DW'(mon_e.k));
          check("tx_last", DW'(bus.m_axis_tx_data_TLAST), DW'(mon_e.l));
        end
        if (bus.m_axis_tx_data_TLAST) open_seg = 1'b0;
      end
      if (bus.s_axis_data_TREADY)
        check("fill_drain_overlap",
              32'(bus.m_axis_tx_data_TVALID || bus.m_axis_tx_metadata_TVALID), 0);
    end
  end

  initial begin
    int n;
    int viol;
    int n_err;

    rst                         = 1'b1;
    bus.s_axis_data_TVALID      = 1'b0;
    bus.s_axis_data_TDATA       = '0;
    bus.s_axis_data_TKEEP       = '0;
    bus.s_axis_data_TLAST       = 1'b0;
    bus.s_axis_session_TVALID   = 1'b0;
    bus.s_axis_session_TDATA    = '0;
    bus.s_axis_tx_status_TVALID = 1'b0;
    bus.s_axis_tx_status_TDATA  = '0;

    repeat (3) @(negedge clk);
    check("rst_meta_valid", 32'(bus.m_axis_tx_metadata_TVALID), 0);
    check("rst_tx_valid", 32'(bus.m_axis_tx_data_TVALID), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_data_ready", 32'(bus.s_axis_data_TREADY), 0);
    check("idle_session_ready", 32'(bus.s_axis_session_TREADY), 1);
    check("idle_err_count", 32'(err_count), 0);
    check("idle_err_sticky", 32'(err_sticky), 0);
    mon_en = 1'b1;

    // Single short message, a 30-beat message cut at MB, then two 1-beat messages.
    add_msg(16'h0005, 3, 64, 1'b0);
    add_msg(16'h0011, 30, 4, 1'b0);
    add_msg(16'h0001, 1, 1, 1'b0);
    add_msg(16'h0002, 1, 64, 1'b0);
    run_traffic();

    // Metadata back-pressure: nothing may move until the metadata is taken.
    meta_hold = 1'b1;
    add_msg(16'h0033, 5, 64, 1'b0);
    fork
      run_traffic();
      begin
        n = 0;
        while (!bus.m_axis_tx_metadata_TVALID && n < TMO) begin
          @(negedge clk);
          n++;
        end
        check("stall_meta_seen", 32'(bus.m_axis_tx_metadata_TVALID), 1);
        viol = 0;
        repeat (50) begin
          @(negedge clk);
          if (bus.m_axis_tx_data_TVALID || bus.s_axis_data_TREADY) viol++;
        end
        check("stall_quiet", 32'(viol), 0);
        check("stall_meta_held", 32'(bus.m_axis_tx_metadata_TVALID), 1);
        meta_hold = 1'b0;
      end
    join

    // Randomized traffic with random keeps, gaps and back-pressure.
    rand_ready = 1'b1;
    tx_mode    = 1;
    gap_max    = 3;
    for (int i = 0; i < 10; i++)
      add_msg(16'($urandom), $urandom_range(1, 50), $urandom_range(1, KW), 1'b1);
    run_traffic();
    rand_ready = 1'b0;
    tx_mode    = 0;
    gap_max    = 0;

    // Reset while the second of four beats is waiting in DRAIN, with another session queued.
    mon_en   = 1'b0;
    tx_force = 1'b0;
    tx_mode  = 2;
    add_msg(16'h0044, 4, 64, 1'b0);
    @(posedge clk);
    #1;
    send_all();
    send_session(16'h0066);
    n = 0;
    @(negedge clk);
    while (!bus.m_axis_tx_data_TVALID && n < TMO) begin
      @(negedge clk);
      n++;
    end
    check("rstdrain_first_valid", 32'(bus.m_axis_tx_data_TVALID), 1);
    tx_force = 1'b1;
    @(negedge clk);
    tx_force = 1'b0;
    @(negedge clk);
    check("rstdrain_beat2_valid", 32'(bus.m_axis_tx_data_TVALID), 1);
    check("rstdrain_beat2_last", 32'(bus.m_axis_tx_data_TLAST), 0);
    rst = 1'b1;
    #1;
    check("rstdrain_tx_valid", 32'(bus.m_axis_tx_data_TVALID), 0);
    check("rstdrain_meta_valid", 32'(bus.m_axis_tx_metadata_TVALID), 0);
    check("rstdrain_data_ready", 32'(bus.s_axis_data_TREADY), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_meta.delete();
    exp_beat.delete();
    viol = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.s_axis_data_TREADY || bus.m_axis_tx_data_TVALID) viol++;
    end
    check("rstdrain_queue_flushed", 32'(viol), 0);
    check("rstdrain_session_ready", 32'(bus.s_axis_session_TREADY), 1);
    open_seg = 1'b0;
    tx_mode  = 0;
    mon_en   = 1'b1;
    add_msg(16'h0055, 1, 6, 1'b0);
    run_traffic();

    // Status errors: three directed, then a few random ones.
    n_err = 0;
    send_status(2'd1);
    send_status(2'd0);
    send_status(2'd2);
    @(negedge clk);
    check("err_count_directed", 32'(err_count), StatusEn ? 2 : 0);
    check("err_sticky_directed", 32'(err_sticky), 32'(StatusEn));
    n_err = 2;
    for (int i = 0; i < 6; i++) begin
      logic [1:0] e;
      e = 2'($urandom_range(0, 3));
      if (e != 2'd0) n_err++;
      send_status(e);
    end
    @(negedge clk);
    check("err_count_random", 32'(err_count), StatusEn ? 32'(n_err) : 0);
    check("err_sticky_random", 32'(err_sticky), 32'(StatusEn));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
